// File: rtl/cw305_axi_arbiter_pkg.sv
// Shared constants for the cw305 mailbox AXI4-Lite arbiter.
//  - Per-channel FSM state encodings (write: IDLE/ADDR/RESP, read: IDLE/ADDR/DATA)
//  - Master index constants M0 (picorv32 core) and M1 (host/debug loader)
package cw305_axi_arbiter_pkg;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/cw305_axi_arbiter_if.sv
// AXI4-Lite bundle, signal meanings as on the picorv32 mem_axi_* port.
//  master modport: drives aw/w/ar valid+payload and b/r ready
//  slave  modport: drives aw/w/ar ready and b/r valid (+ rdata)
interface cw305_axi_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              wvalid, wready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic              bvalid, bready;
  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              rvalid, rready;
  logic [DATA_W-1:0] rdata;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, arready, rvalid, rdata
  );
endinterface

// File: rtl/cw305_axi_arbiter_rr_arb2.sv
// Two-request grant picker with an owner register.
//  clk, reset  : clock, synchronous active-high reset (owner resets to M1 so M0 wins first contest)
//  req_i[1:0]  : request per master
//  take_i      : channel is idle and may accept a new grant this cycle
//  owner_o     : current/last granted master (doubles as the grant select while busy)
module cw305_rr_arb2
  import cw305_axi_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic       owner_o
);

  logic owner_q, owner_d, pick;

  always_comb begin
    pick = owner_q;
    unique case (req_i)
      2'b01:   pick = M0;
      2'b10:   pick = M1;
      // contested: fixed priority favours M0, otherwise hand it to whoever did not have it last
      2'b11:   pick = (FIXED_PRIO != 0) ? M0 : ~owner_q;
      default: pick = owner_q;
    endcase
  end

  always_comb begin
    owner_d = owner_q;
    if (take_i && (req_i != 2'b00)) owner_d = pick;
  end

  always_ff @(posedge clk) begin
    if (reset) owner_q <= M1;
    else       owner_q <= owner_d;
  end

  assign owner_o = owner_q;

endmodule

// File: rtl/cw305_axi_arbiter.sv
// 2:1 AXI4-Lite arbiter in front of the cw305_axi mailbox slave.
//  clk, reset        : single clock, synchronous active-high reset
//  m0_axi, m1_axi    : master ports (picorv32 core, host/debug loader)
//  s_axi             : toward cw305_axi
//  wr_owner/rd_owner : current/last granted master per channel
//  wr_busy/rd_busy   : channel FSM not idle
// Read and write channels are arbitrated independently; a grant covers a whole
// transaction. The arbiter's owner register is also the mux select while busy.
module cw305_axi_arbiter
  import cw305_axi_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic clk,
  input  logic reset,
  cw305_axi_arbiter_if.slave  m0_axi,
  cw305_axi_arbiter_if.slave  m1_axi,
  cw305_axi_arbiter_if.master s_axi,
  output logic wr_owner,
  output logic rd_owner,
  output logic wr_busy,
  output logic rd_busy
);

  // ---------------- write channel ----------------
  logic [1:0] wst_q, wst_d;
  logic       aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic       wsel;
  logic       awvalid_sel, wvalid_sel, bready_sel;
  logic [ADDR_W-1:0]   awaddr_sel;
  logic [DATA_W-1:0]   wdata_sel;
  logic [DATA_W/8-1:0] wstrb_sel;
  logic       s_awvalid, s_wvalid, s_bready;
  logic       aw_rdy, w_rdy, b_route, aw_hs, w_hs, b_hs;

  cw305_rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_wr_arb (
    .clk     (clk),
    .reset   (reset),
    .req_i   ({m1_axi.awvalid, m0_axi.awvalid}),
    .take_i  (wst_q == W_IDLE),
    .owner_o (wsel)
  );

  assign awvalid_sel = wsel ? m1_axi.awvalid : m0_axi.awvalid;
  assign wvalid_sel  = wsel ? m1_axi.wvalid  : m0_axi.wvalid;
  assign bready_sel  = wsel ? m1_axi.bready  : m0_axi.bready;
  assign awaddr_sel  = wsel ? m1_axi.awaddr  : m0_axi.awaddr;
  assign wdata_sel   = wsel ? m1_axi.wdata   : m0_axi.wdata;
  assign wstrb_sel   = wsel ? m1_axi.wstrb   : m0_axi.wstrb;

  // once a channel has handshaken it is masked off for the rest of the burst
  assign s_awvalid = (wst_q == W_ADDR) && !aw_done_q && awvalid_sel;
  assign s_wvalid  = (wst_q == W_ADDR) && !w_done_q  && wvalid_sel;
  assign aw_rdy    = (wst_q == W_ADDR) && !aw_done_q && s_axi.awready;
  assign w_rdy     = (wst_q == W_ADDR) && !w_done_q  && s_axi.wready;
  assign b_route   = (wst_q == W_RESP);
  assign s_bready  = b_route && bready_sel;
  assign aw_hs     = s_awvalid && s_axi.awready;
  assign w_hs      = s_wvalid  && s_axi.wready;
  assign b_hs      = s_bready  && s_axi.bvalid;

  assign s_axi.awvalid = s_awvalid;
  assign s_axi.awaddr  = awaddr_sel;
  assign s_axi.awprot  = wsel ? m1_axi.awprot : m0_axi.awprot;
  assign s_axi.wvalid  = s_wvalid;
  assign s_axi.wdata   = wdata_sel;
  assign s_axi.wstrb   = wstrb_sel;
  assign s_axi.bready  = s_bready;

  assign m0_axi.awready = aw_rdy && (wsel == M0);
  assign m1_axi.awready = aw_rdy && (wsel == M1);
  assign m0_axi.wready  = w_rdy  && (wsel == M0);
  assign m1_axi.wready  = w_rdy  && (wsel == M1);
  assign m0_axi.bvalid  = b_route && (wsel == M0) && s_axi.bvalid;
  assign m1_axi.bvalid  = b_route && (wsel == M1) && s_axi.bvalid;

  always_comb begin
    wst_d     = wst_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (wst_q)
      W_IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (m0_axi.awvalid || m1_axi.awvalid) wst_d = W_ADDR;
      end
      W_ADDR: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q  | w_hs;
        if (aw_done_d && w_done_d) begin
          wst_d     = W_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      W_RESP:  if (b_hs) wst_d = W_IDLE;
      default: wst_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wst_q     <= W_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      wst_q     <= wst_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // ---------------- read channel ----------------
  logic [1:0] rst_q, rst_d;
  logic       rsel;
  logic       arvalid_sel, rready_sel;
  logic [ADDR_W-1:0] araddr_sel;
  logic       s_arvalid, s_rready, ar_hs, r_hs, r_route;

  cw305_rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_rd_arb (
    .clk     (clk),
    .reset   (reset),
    .req_i   ({m1_axi.arvalid, m0_axi.arvalid}),
    .take_i  (rst_q == R_IDLE),
    .owner_o (rsel)
  );

  assign arvalid_sel = rsel ? m1_axi.arvalid : m0_axi.arvalid;
  assign rready_sel  = rsel ? m1_axi.rready  : m0_axi.rready;
  assign araddr_sel  = rsel ? m1_axi.araddr  : m0_axi.araddr;

  assign s_arvalid = (rst_q == R_ADDR) && arvalid_sel;
  assign r_route   = (rst_q == R_DATA);
  assign s_rready  = r_route && rready_sel;
  assign ar_hs     = s_arvalid && s_axi.arready;
  assign r_hs      = s_rready  && s_axi.rvalid;

  assign s_axi.arvalid = s_arvalid;
  assign s_axi.araddr  = araddr_sel;
  assign s_axi.arprot  = rsel ? m1_axi.arprot : m0_axi.arprot;
  assign s_axi.rready  = s_rready;

  assign m0_axi.arready = (rst_q == R_ADDR) && (rsel == M0) && s_axi.arready;
  assign m1_axi.arready = (rst_q == R_ADDR) && (rsel == M1) && s_axi.arready;
  assign m0_axi.rvalid  = r_route && (rsel == M0) && s_axi.rvalid;
  assign m1_axi.rvalid  = r_route && (rsel == M1) && s_axi.rvalid;
  assign m0_axi.rdata   = (r_route && (rsel == M0)) ? s_axi.rdata : '0;
  assign m1_axi.rdata   = (r_route && (rsel == M1)) ? s_axi.rdata : '0;

  always_comb begin
    rst_d = rst_q;
    unique case (rst_q)
      R_IDLE:  if (m0_axi.arvalid || m1_axi.arvalid) rst_d = R_ADDR;
      R_ADDR:  if (ar_hs) rst_d = R_DATA;
      R_DATA:  if (r_hs)  rst_d = R_IDLE;
      default: rst_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) rst_q <= R_IDLE;
    else       rst_q <= rst_d;
  end

  // ---------------- status ----------------
  assign wr_owner = wsel;
  assign rd_owner = rsel;
  assign wr_busy  = (wst_q != W_IDLE);
  assign rd_busy  = (rst_q != R_IDLE);

endmodule

// File: tb/tb_cw305_axi_arbiter.sv
// Directed bench for cw305_axi_arbiter: round-robin instance with a full
// mailbox slave model, plus a FIXED_PRIO instance exercised on reads only.
module tb_cw305_axi_arbiter;

  localparam int LIM = 60;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cw305_axi_arbiter_if m0_if(), m1_if(), s_if(), f0_if(), f1_if(), fs_if();
  logic wr_owner, rd_owner, wr_busy, rd_busy;
  logic f_wo, f_ro, f_wb, f_rb;

  cw305_axi_arbiter #(.FIXED_PRIO(0)) dut (
    .clk(clk), .reset(reset), .m0_axi(m0_if), .m1_axi(m1_if), .s_axi(s_if),
    .wr_owner(wr_owner), .rd_owner(rd_owner), .wr_busy(wr_busy), .rd_busy(rd_busy));

  cw305_axi_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk(clk), .reset(reset), .m0_axi(f0_if), .m1_axi(f1_if), .s_axi(fs_if),
    .wr_owner(f_wo), .rd_owner(f_ro), .wr_busy(f_wb), .rd_busy(f_rb));

  // ---------------- master drive/observe arrays ----------------
  logic        awv[2], wv[2], bre[2], arv[2], rre[2];
  logic [31:0] awa[2], wd[2], ara[2];
  logic [3:0]  ws[2];
  logic        awr[2], wrd[2], bv[2], arr[2], rv[2];
  logic [31:0] rd[2];

  assign m0_if.awvalid = awv[0]; assign m0_if.awaddr = awa[0]; assign m0_if.awprot = 3'b000;
  assign m0_if.wvalid  = wv[0];  assign m0_if.wdata  = wd[0];  assign m0_if.wstrb  = ws[0];
  assign m0_if.bready  = bre[0]; assign m0_if.arvalid = arv[0]; assign m0_if.araddr = ara[0];
  assign m0_if.arprot  = 3'b000; assign m0_if.rready = rre[0];
  assign m1_if.awvalid = awv[1]; assign m1_if.awaddr = awa[1]; assign m1_if.awprot = 3'b000;
  assign m1_if.wvalid  = wv[1];  assign m1_if.wdata  = wd[1];  assign m1_if.wstrb  = ws[1];
  assign m1_if.bready  = bre[1]; assign m1_if.arvalid = arv[1]; assign m1_if.araddr = ara[1];
  assign m1_if.arprot  = 3'b000; assign m1_if.rready = rre[1];
  assign awr[0] = m0_if.awready; assign wrd[0] = m0_if.wready; assign bv[0] = m0_if.bvalid;
  assign arr[0] = m0_if.arready; assign rv[0]  = m0_if.rvalid; assign rd[0] = m0_if.rdata;
  assign awr[1] = m1_if.awready; assign wrd[1] = m1_if.wready; assign bv[1] = m1_if.bvalid;
  assign arr[1] = m1_if.arready; assign rv[1]  = m1_if.rvalid; assign rd[1] = m1_if.rdata;

  // fixed-priority instance: reads only, write side tied off
  logic        farv[2], farr[2], frv[2];
  logic [31:0] fara[2], frdt[2];
  assign f0_if.awvalid = 1'b0; assign f0_if.awaddr = '0; assign f0_if.awprot = '0;
  assign f0_if.wvalid  = 1'b0; assign f0_if.wdata  = '0; assign f0_if.wstrb  = '0;
  assign f0_if.bready  = 1'b0; assign f0_if.arvalid = farv[0]; assign f0_if.araddr = fara[0];
  assign f0_if.arprot  = '0;   assign f0_if.rready = 1'b1;
  assign f1_if.awvalid = 1'b0; assign f1_if.awaddr = '0; assign f1_if.awprot = '0;
  assign f1_if.wvalid  = 1'b0; assign f1_if.wdata  = '0; assign f1_if.wstrb  = '0;
  assign f1_if.bready  = 1'b0; assign f1_if.arvalid = farv[1]; assign f1_if.araddr = fara[1];
  assign f1_if.arprot  = '0;   assign f1_if.rready = 1'b1;
  assign farr[0] = f0_if.arready; assign frv[0] = f0_if.rvalid; assign frdt[0] = f0_if.rdata;
  assign farr[1] = f1_if.arready; assign frv[1] = f1_if.rvalid; assign frdt[1] = f1_if.rdata;

  // ---------------- slave models ----------------
  logic        s_awg, s_wg, s_bv, s_rv, f_rv;
  logic [31:0] s_rdata, f_rdata, last_aw, last_wd;
  logic [3:0]  last_ws;
  int          s_wr_cnt = 0;

  assign s_if.awready = 1'b1; assign s_if.wready = 1'b1; assign s_if.bvalid = s_bv;
  assign s_if.arready = 1'b1; assign s_if.rvalid = s_rv; assign s_if.rdata  = s_rdata;
  assign fs_if.awready = 1'b0; assign fs_if.wready = 1'b0; assign fs_if.bvalid = 1'b0;
  assign fs_if.arready = 1'b1; assign fs_if.rvalid = f_rv; assign fs_if.rdata  = f_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      s_awg <= 1'b0; s_wg <= 1'b0; s_bv <= 1'b0; s_rv <= 1'b0; f_rv <= 1'b0;
    end else begin
      if (s_if.awvalid && s_if.awready) begin s_awg <= 1'b1; last_aw <= s_if.awaddr; end
      if (s_if.wvalid && s_if.wready) begin
        s_wg <= 1'b1; last_wd <= s_if.wdata; last_ws <= s_if.wstrb;
      end
      if (s_awg && s_wg) begin
        s_bv <= 1'b1; s_awg <= 1'b0; s_wg <= 1'b0; s_wr_cnt <= s_wr_cnt + 1;
      end
      if (s_bv && s_if.bready) s_bv <= 1'b0;
      // read data echoes the address
      if (s_if.arvalid && s_if.arready) begin s_rv <= 1'b1; s_rdata <= s_if.araddr; end
      else if (s_rv && s_if.rready) s_rv <= 1'b0;
      if (fs_if.arvalid && fs_if.arready) begin f_rv <= 1'b1; f_rdata <= fs_if.araddr; end
      else if (f_rv && fs_if.rready) f_rv <= 1'b0;
    end
  end

  // ---------------- handshake monitors ----------------
  int m0_b = 0, m1_b = 0, m1_bv_cyc = 0;
  logic [32:0] rlog[$];
  logic [32:0] flog[$];

  always @(posedge clk) begin
    if (bv[0] && bre[0]) m0_b <= m0_b + 1;
    if (bv[1] && bre[1]) m1_b <= m1_b + 1;
    if (bv[1])           m1_bv_cyc <= m1_bv_cyc + 1;
    if (rv[0] && rre[0]) rlog.push_back({1'b0, rd[0]});
    if (rv[1] && rre[1]) rlog.push_back({1'b1, rd[1]});
    if (frv[0]) flog.push_back({1'b0, frdt[0]});
    if (frv[1]) flog.push_back({1'b1, frdt[1]});
  end

  // ---------------- checking ----------------
  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- master tasks ----------------
  task automatic rd_txn(input int m, input logic [31:0] a, output logic [31:0] d);
    int n; logic hs;
    arv[m] = 1'b1; ara[m] = a; n = 0; hs = 1'b0;
    while (!hs && n < LIM) begin
      @(negedge clk); hs = arr[m];
      @(posedge clk); #1; n++;
    end
    arv[m] = 1'b0;
    chk("rd_ar_bound", hs, 1);
    n = 0; @(negedge clk);
    while (!rv[m] && n < LIM) begin @(negedge clk); n++; end
    chk("rd_r_bound", rv[m], 1);
    d = rd[m];
    @(posedge clk); #1;
  endtask

  task automatic frd_txn(input int m, input logic [31:0] a);
    int n; logic hs;
    farv[m] = 1'b1; fara[m] = a; n = 0; hs = 1'b0;
    while (!hs && n < LIM) begin
      @(negedge clk); hs = farr[m];
      @(posedge clk); #1; n++;
    end
    farv[m] = 1'b0;
    chk("frd_ar_bound", hs, 1);
    n = 0; @(negedge clk);
    while (!frv[m] && n < LIM) begin @(negedge clk); n++; end
    chk("frd_r_bound", frv[m], 1);
    @(posedge clk); #1;
  endtask

  // wlead: cycles W is presented before AW; bdly: cycles bready is held low after bvalid
  task automatic wr_txn(input int m, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int wlead, input int bdly);
    int n; logic awd, wdn, ha, hw;
    wv[m] = 1'b1; wd[m] = d; ws[m] = s;
    repeat (wlead) begin @(posedge clk); #1; end
    awv[m] = 1'b1; awa[m] = a; awd = 1'b0; wdn = 1'b0; n = 0;
    while (!(awd && wdn) && n < LIM) begin
      @(negedge clk); ha = awr[m]; hw = wrd[m];
      @(posedge clk); #1; n++;
      if (ha) begin awv[m] = 1'b0; awd = 1'b1; end
      if (hw) begin wv[m]  = 1'b0; wdn = 1'b1; end
    end
    chk("wr_aw_w_bound", awd && wdn, 1);
    n = 0; @(negedge clk);
    while (!bv[m] && n < LIM) begin @(negedge clk); n++; end
    chk("wr_b_bound", bv[m], 1);
    repeat (bdly) @(negedge clk);
    bre[m] = 1'b1;
    @(posedge clk); #1;
    bre[m] = 1'b0;
  endtask

  // ---------------- sequence ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d0, d1, d2, d3, d4;
    int b0, b1, bc, wc, base;

    for (int i = 0; i < 2; i++) begin
      awv[i] = 0; wv[i] = 0; bre[i] = 0; arv[i] = 0; rre[i] = 1;
      awa[i] = 0; wd[i] = 0; ws[i] = 0; ara[i] = 0; farv[i] = 0; fara[i] = 0;
    end

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_owners", {wr_owner, rd_owner}, 2'b11);
    chk("rst_outs", {s_if.awvalid, s_if.wvalid, s_if.bready, s_if.arvalid, s_if.rready,
                     awr[0], awr[1], wrd[0], wrd[1], bv[0], bv[1], arr[0], arr[1],
                     rv[0], rv[1], wr_busy, rd_busy}, 0);
    @(posedge clk); #1 reset = 1'b0;

    // contested read right after reset: m0 first
    fork
      rd_txn(0, 32'h460, d0);
      rd_txn(1, 32'h464, d1);
    join
    chk("contest_d0", d0, 32'h460);
    chk("contest_d1", d1, 32'h464);
    chk("contest_first", rlog[0], {1'b0, 32'h460});
    chk("contest_second", rlog[1], {1'b1, 32'h464});
    chk("contest_rd_owner", rd_owner, 1);

    // single m0 write
    b0 = m0_b; bc = m1_bv_cyc; wc = s_wr_cnt;
    wr_txn(0, 32'h47C, 32'hDEADBEEF, 4'hF, 0, 0);
    chk("w0_awaddr", last_aw, 32'h47C);
    chk("w0_wdata", last_wd, 32'hDEADBEEF);
    chk("w0_wstrb", last_ws, 4'hF);
    chk("w0_slave_writes", s_wr_cnt - wc, 1);
    chk("w0_m0_b", m0_b - b0, 1);
    chk("w0_m1_bvalid", m1_bv_cyc - bc, 0);
    chk("w0_wr_owner", wr_owner, 0);

    // m0 streams two reads against one m1 read: contested grants alternate
    base = rlog.size();
    fork
      begin rd_txn(0, 32'h500, d2); rd_txn(0, 32'h508, d3); end
      rd_txn(1, 32'h504, d4);
    join
    chk("rr_order0", rlog[base],   {1'b0, 32'h500});
    chk("rr_order1", rlog[base+1], {1'b1, 32'h504});
    chk("rr_order2", rlog[base+2], {1'b0, 32'h508});

    // concurrent m0 read + m1 write: both channels granted on the same edge
    wc = s_wr_cnt;
    fork
      rd_txn(0, 32'h470, d0);
      wr_txn(1, 32'h474, 32'hCAFEF00D, 4'hF, 0, 0);
      begin
        @(posedge clk); @(negedge clk);
        chk("conc_busy", {wr_busy, rd_busy}, 2'b11);
        chk("conc_owners", {wr_owner, rd_owner}, 2'b10);
      end
    join
    chk("conc_rdata", d0, 32'h470);
    chk("conc_awaddr", last_aw, 32'h474);
    chk("conc_wdata", last_wd, 32'hCAFEF00D);
    chk("conc_writes", s_wr_cnt - wc, 1);

    // m1 presents W two cycles ahead of AW, then stalls bready so bvalid is held 3 cycles
    b0 = m0_b; b1 = m1_b; bc = m1_bv_cyc; wc = s_wr_cnt;
    wr_txn(1, 32'h480, 32'h12345678, 4'h3, 2, 2);
    chk("wlead_writes", s_wr_cnt - wc, 1);
    chk("wlead_awaddr", last_aw, 32'h480);
    chk("wlead_wdata", last_wd, 32'h12345678);
    chk("wlead_wstrb", last_ws, 4'h3);
    chk("wlead_m1_b", m1_b - b1, 1);
    chk("wlead_m1_bv_cycles", m1_bv_cyc - bc, 3);
    chk("wlead_m0_b", m0_b - b0, 0);

    // reset while m0's response is pending
    b0 = m0_b;
    fork
      wr_txn(0, 32'h490, 32'h0BADF00D, 4'hF, 0, 8);
      begin
        int n = 0;
        @(negedge clk);
        while (!(wr_busy && s_bv) && n < LIM) begin @(negedge clk); n++; end
        chk("rst_mid_reach_resp", wr_busy && s_bv, 1);
        chk("rst_mid_owner_before", wr_owner, 0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rst_mid_owners", {wr_owner, rd_owner}, 2'b11);
        chk("rst_mid_outs", {s_if.awvalid, s_if.wvalid, s_if.bready, s_if.arvalid, s_if.rready,
                             awr[0], awr[1], wrd[0], wrd[1], bv[0], bv[1], arr[0], arr[1],
                             rv[0], rv[1], wr_busy, rd_busy}, 0);
        chk("rst_mid_rdata", {rd[0], rd[1]}, 0);
        @(posedge clk); #1 reset = 1'b0;
      end
    join
    chk("rst_mid_no_b", m0_b - b0, 0);

    // fixed priority: m0 stream of four completes before any m1 read
    base = flog.size();
    fork
      for (int i = 0; i < 4; i++) frd_txn(0, 32'h600 + 32'(i * 8));
      for (int i = 0; i < 4; i++) frd_txn(1, 32'h700 + 32'(i * 8));
    join
    for (int k = 0; k < 4; k++) chk("fp_m0_first", flog[base+k], {1'b0, 32'h600 + 32'(k * 8)});
    for (int k = 0; k < 4; k++) chk("fp_m1_after", flog[base+4+k], {1'b1, 32'h700 + 32'(k * 8)});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
